// File: rtl/clock_alarm_core.sv
// Timekeeping core: configurable tick, RUN/SET_TIME/SET_ALARM mode machine,
// alarm with ring timeout and snooze, BCD digit outputs for 12/24 h display.

module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    logic [2:0] sync_pipe;

    // two sync stages plus one history stage; the pulse is registered so a
    // press sampled at edge N reaches the core registers at edge N+3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= '0;
            press     <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], btn};
            press     <= sync_pipe[1] & ~sync_pipe[2];
        end
    end
endmodule

module clock_alarm_core #(
    parameter int TIC_MAX       = 50_000_000,
    parameter int ALARM_LEN_S   = 60,
    parameter int SNOOZE_MIN    = 5,
    parameter int ALARM_RST_HR  = 7,
    parameter int ALARM_RST_MIN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       hora,
    input  logic       min,
    input  logic       snooze,
    input  logic       mode,
    input  logic       alarm_en,
    output logic [3:0] sec_u,
    output logic [3:0] sec_d,
    output logic [3:0] min_u,
    output logic [3:0] min_d,
    output logic [3:0] hr_u,
    output logic [3:0] hr_d,
    output logic       pm,
    output logic [1:0] state_o,
    output logic       buzz
);
    localparam int TW = (TIC_MAX > 1) ? $clog2(TIC_MAX) : 1;

    typedef enum logic [1:0] {RUN = 2'b00, SET_TIME = 2'b01, SET_ALARM = 2'b10} state_t;

    logic [3:0] btn_raw, btn_press;
    assign btn_raw = {snooze, min, hora, set};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_edge u_btn (.clk(clk), .rst(rst), .btn(btn_raw[i]), .press(btn_press[i]));
        end
    endgenerate

    logic p_set, p_hr, p_min, p_snz;
    assign {p_snz, p_min, p_hr, p_set} = btn_press;

    state_t      state;
    logic [TW-1:0] tic;
    logic [5:0]  sec, minute, al_min, snz_cnt;
    logic [4:0]  hour, al_hr;
    logic [7:0]  ring;

    logic       tick, running, sec_wrap, alarm_hit;
    logic [5:0] nxt_min;
    logic [4:0] nxt_hr;

    assign tick      = (tic == TW'(TIC_MAX - 1));
    assign running   = (state != SET_TIME);
    assign sec_wrap  = running && tick && (sec == 6'd59);
    assign nxt_min   = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
    assign nxt_hr    = (minute != 6'd59) ? hour : (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    assign alarm_hit = sec_wrap && alarm_en && (nxt_min == al_min) && (nxt_hr == al_hr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            tic     <= '0;
            sec     <= '0;
            minute  <= '0;
            hour    <= '0;
            al_hr   <= 5'(ALARM_RST_HR);
            al_min  <= 6'(ALARM_RST_MIN);
            ring    <= '0;
            snz_cnt <= '0;
            buzz    <= 1'b0;
        end else begin
            if (!running)  tic <= '0;
            else if (tick) tic <= '0;
            else           tic <= tic + TW'(1);

            if (running && tick) begin
                sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
                if (sec == 6'd59) begin
                    minute <= nxt_min;
                    hour   <= nxt_hr;
                end
            end

            if (buzz && tick) begin
                if (ring <= 8'd1) begin
                    buzz <= 1'b0;
                    ring <= '0;
                end else begin
                    ring <= ring - 8'd1;
                end
            end

            // snooze counts minute rollovers; expiry starts a fresh ring
            if (sec_wrap && snz_cnt != 6'd0) begin
                snz_cnt <= snz_cnt - 6'd1;
                if (snz_cnt == 6'd1) begin
                    buzz <= 1'b1;
                    ring <= 8'(ALARM_LEN_S);
                end
            end

            if (alarm_hit) begin
                buzz <= 1'b1;
                ring <= 8'(ALARM_LEN_S);
            end

            if (p_snz && buzz) begin
                buzz    <= 1'b0;
                snz_cnt <= 6'(SNOOZE_MIN);
            end

            if (!alarm_en) begin
                buzz    <= 1'b0;
                snz_cnt <= '0;
            end

            if (p_set) begin
                case (state)
                    RUN: begin
                        state   <= SET_TIME;
                        sec     <= '0;
                        tic     <= '0;
                        buzz    <= 1'b0;
                        snz_cnt <= '0;
                        ring    <= '0;
                    end
                    SET_TIME:  state <= SET_ALARM;
                    default:   state <= RUN;
                endcase
            end else if (state == SET_TIME) begin
                if (p_hr)  hour   <= (hour == 5'd23)   ? 5'd0 : hour + 5'd1;
                if (p_min) minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
            end else if (state == SET_ALARM) begin
                if (p_hr)  al_hr  <= (al_hr == 5'd23)  ? 5'd0 : al_hr + 5'd1;
                if (p_min) al_min <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
            end
        end
    end

    assign state_o = state;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t, u;
        if      (v >= 6'd50) begin t = 4'd5; u = 4'(v - 6'd50); end
        else if (v >= 6'd40) begin t = 4'd4; u = 4'(v - 6'd40); end
        else if (v >= 6'd30) begin t = 4'd3; u = 4'(v - 6'd30); end
        else if (v >= 6'd20) begin t = 4'd2; u = 4'(v - 6'd20); end
        else if (v >= 6'd10) begin t = 4'd1; u = 4'(v - 6'd10); end
        else                 begin t = 4'd0; u = v[3:0]; end
        return {t, u};
    endfunction

    logic [4:0] disp_hr, hr_show;
    logic [5:0] disp_min, disp_sec;

    always_comb begin
        disp_hr  = (state == SET_ALARM) ? al_hr  : hour;
        disp_min = (state == SET_ALARM) ? al_min : minute;
        disp_sec = (state == SET_ALARM) ? 6'd0   : sec;
        hr_show  = disp_hr;
        pm       = 1'b0;
        if (!mode) begin
            if (disp_hr == 5'd0) begin
                hr_show = 5'd12;
            end else if (disp_hr >= 5'd12) begin
                pm = 1'b1;
                if (disp_hr > 5'd12) hr_show = disp_hr - 5'd12;
            end
        end
    end

    assign {sec_d, sec_u} = to_bcd(disp_sec);
    assign {min_d, min_u} = to_bcd(disp_min);
    assign {hr_d,  hr_u}  = to_bcd({1'b0, hr_show});
endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with a small tick (TIC_MAX=4); expected
// values are queued at stimulus time and popped when the DUT output is sampled.

module tb_clock_alarm_core;
    logic clk = 1'b0;
    logic rst, set, hora, min, snooze, mode, alarm_en;
    logic [3:0] sec_u, sec_d, min_u, min_d, hr_u, hr_d;
    logic pm, buzz;
    logic [1:0] state_o;

    clock_alarm_core #(
        .TIC_MAX(4), .ALARM_LEN_S(3), .SNOOZE_MIN(5), .ALARM_RST_HR(7), .ALARM_RST_MIN(0)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .hora(hora), .min(min), .snooze(snooze),
        .mode(mode), .alarm_en(alarm_en),
        .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d), .hr_u(hr_u), .hr_d(hr_d),
        .pm(pm), .state_o(state_o), .buzz(buzz)
    );

    always #5 clk = ~clk;

    logic [23:0] digits;
    assign digits = {hr_d, hr_u, min_d, min_u, sec_d, sec_u};

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [3:0] B_SET = 4'b0001, B_HR = 4'b0010, B_MN = 4'b0100;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: observed %0h with no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one-cycle press; returns just after the edge where the press takes effect
    task automatic press(input logic [3:0] b);
        {snooze, min, hora, set} = b;
        @(negedge clk);
        {snooze, min, hora, set} = 4'b0000;
        step(3);
    endtask

    initial begin
        rst = 1'b1; set = 1'b0; hora = 1'b0; min = 1'b0; snooze = 1'b0;
        mode = 1'b0; alarm_en = 1'b0;
        step(3);

        // reset state
        expect_val("rst_digits_12h", 'h120000); chk(32'(digits));
        expect_val("rst_pm_12h", 0);            chk(32'(pm));
        mode = 1'b1; #1;
        expect_val("rst_digits_24h", 'h000000); chk(32'(digits));
        expect_val("rst_buzz", 0);              chk(32'(buzz));
        expect_val("rst_state", 0);             chk(32'(state_o));
        step(1);
        rst = 1'b0;

        // preload 23:59 and let the clock wrap the day
        press(B_SET);
        expect_val("enter_set_time", 1);        chk(32'(state_o));
        repeat (23) press(B_HR);
        repeat (59) press(B_MN);
        expect_val("set_time_2359", 'h235900);  chk(32'(digits));
        press(B_SET);
        expect_val("enter_set_alarm", 2);       chk(32'(state_o));
        expect_val("alarm_rst_disp", 'h070000); chk(32'(digits));
        press(B_SET);
        expect_val("back_to_run", 0);           chk(32'(state_o));
        expect_val("run_first_sec", 'h235901);  chk(32'(digits));
        step(232);
        expect_val("pre_wrap_24h", 'h235959);   chk(32'(digits));
        mode = 1'b0; #1;
        expect_val("pre_wrap_12h", 'h115959);   chk(32'(digits));
        expect_val("pre_wrap_pm", 1);           chk(32'(pm));
        mode = 1'b1;
        step(4);
        expect_val("day_wrap", 'h000000);       chk(32'(digits));
        mode = 1'b0; #1;
        expect_val("midnight_12h", 'h120000);   chk(32'(digits));
        expect_val("midnight_pm", 0);           chk(32'(pm));
        mode = 1'b1;

        // hour/minute setting, minute wraps without hour carry
        press(B_SET);
        repeat (13) press(B_HR);
        repeat (61) press(B_MN);
        expect_val("set_1301", 'h130100);       chk(32'(digits));
        mode = 1'b0; #1;
        expect_val("set_1301_12h", 'h010100);   chk(32'(digits));
        expect_val("set_1301_pm", 1);           chk(32'(pm));
        mode = 1'b1;

        // alarm 00:02, time 00:01:00
        repeat (11) press(B_HR);
        press(B_SET);
        expect_val("alarm_disp_0700", 'h070000); chk(32'(digits));
        repeat (16) press(B_HR);
        press(B_MN);
        press(B_HR | B_MN);
        expect_val("alarm_disp_0002", 'h000200); chk(32'(digits));
        alarm_en = 1'b1;
        press(B_SET);
        expect_val("run_again", 0);             chk(32'(state_o));
        step(163);
        expect_val("pre_alarm_time", 'h000159); chk(32'(digits));
        expect_val("pre_alarm_buzz", 0);       chk(32'(buzz));
        step(1);
        expect_val("alarm_time", 'h000200);     chk(32'(digits));
        expect_val("alarm_buzz_rise", 1);       chk(32'(buzz));

        // snooze: buzz drops three edges after the press edge
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        step(2);
        expect_val("snooze_latency_hold", 1);   chk(32'(buzz));
        step(1);
        expect_val("snooze_clear", 0);          chk(32'(buzz));
        step(1195);
        expect_val("pre_snooze_time", 'h000659); chk(32'(digits));
        expect_val("pre_snooze_buzz", 0);       chk(32'(buzz));
        step(1);
        expect_val("snooze_time", 'h000700);    chk(32'(digits));
        expect_val("snooze_rering", 1);         chk(32'(buzz));
        step(11);
        expect_val("ring_last_cycle", 1);       chk(32'(buzz));
        step(1);
        expect_val("ring_timeout", 0);          chk(32'(buzz));

        // alarm_en drop while ringing in SET_ALARM, then async reset
        press(B_SET);
        press(B_SET);
        expect_val("set_alarm_again", 2);       chk(32'(state_o));
        repeat (6) press(B_MN);
        expect_val("alarm_disp_0008", 'h000800); chk(32'(digits));
        step(215);
        expect_val("pre_0008_buzz", 0);         chk(32'(buzz));
        step(1);
        expect_val("alarm_in_set_alarm", 1);    chk(32'(buzz));
        alarm_en = 1'b0;
        step(1);
        expect_val("alarm_en_drop", 0);         chk(32'(buzz));
        expect_val("still_set_alarm", 2);       chk(32'(state_o));
        rst = 1'b1; #1;
        expect_val("async_rst_state", 0);       chk(32'(state_o));
        expect_val("async_rst_digits", 'h000000); chk(32'(digits));
        step(2);
        rst = 1'b0;
        press(B_SET);
        press(B_SET);
        expect_val("post_rst_alarm", 'h070000); chk(32'(digits));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_alarm_core.md
# clock_alarm_core

Parametrised timekeeping core for the configurable digital clock. It replaces the fixed-rate counter chain with a single block that provides a configurable tick rate, an explicit RUN / SET_TIME / SET_ALARM state machine, and a programmable alarm with ring timeout and snooze. It outputs BCD digits, a PM flag and a buzzer line, and sits between the board push-buttons/switches and the six `deco_bcd_7seg` instances.

## Interface
- `TIC_MAX`, 50_000_000: clock cycles per second.
- `ALARM_LEN_S`, 60: seconds the buzzer rings before auto-off (1..255).
- `SNOOZE_MIN`, 5: snooze delay in minutes (1..59).
- `ALARM_RST_HR`, 7: alarm hour after reset (0..23).
- `ALARM_RST_MIN`, 0: alarm minute after reset (0..59).

- `clk` in 1: system clock; the single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `set` in 1: push-button, raw; each press advances the mode.
- `hora` in 1: push-button, raw; hour +1.
- `min` in 1: push-button, raw; minute +1.
- `snooze` in 1: push-button, raw.
- `mode` in 1: switch; 0 = 12 h display, 1 = 24 h display.
- `alarm_en` in 1: switch; 1 = alarm armed.
- `sec_u`, `sec_d`, `min_u`, `min_d`, `hr_u`, `hr_d` out 4 each: BCD display digits.
- `pm` out 1: PM indicator. Always 0 in 24 h mode.
- `state_o` out 2: 00 RUN, 01 SET_TIME, 10 SET_ALARM.
- `buzz` out 1: alarm ringing.

## Operation
- **Buttons:** each is passed through a 2-FF synchroniser and a rising-edge detector, giving exactly one action per press. A held button gives no repeat.
- **Tick:** the tic counter runs 0..TIC_MAX-1, width `$clog2(TIC_MAX)`. A one-cycle tick fires at TIC_MAX-1.
- **Time registers:** binary sec 0..59, minute 0..59, hour 0..23.
  - In RUN and SET_ALARM, a tick increments sec.
  - Sec 59→0 carries to minute; minute 59→0 carries to hour; hour 23→0 wraps.
- **FSM:** a set press moves RUN→SET_TIME→SET_ALARM→RUN. Reset state is RUN.
- **SET_TIME:**
  - On entry, sec and the tic counter clear; time is frozen.
  - `hora` increments hour mod 24.
  - `min` increments minute mod 60, with no carry into the hour.
  - On entry, `buzz` and snooze also clear.
- **SET_ALARM:**
  - Time keeps running normally.
  - `hora` / `min` adjust the alarm hour/minute mod 24 / mod 60.
  - The display shows alarm hh:mm with seconds 00.
- **Press priority:** a set press in the same cycle as `hora` / `min` takes priority; those presses are dropped. `hora` and `min` pressed in the same cycle both apply.
- **Alarm match:** evaluated in RUN and SET_ALARM when sec wraps 59→0. If `alarm_en`=1 and the new hh:mm equals the alarm hh:mm, `buzz` is set and the ring counter loads ALARM_LEN_S.
- **Ring timeout:** the ring counter decrements once per tick while `buzz`=1. When it reaches 0, `buzz` clears.
- **Snooze:**
  - A snooze press while `buzz`=1 clears `buzz` and loads the snooze counter with SNOOZE_MIN.
  - The snooze counter decrements on each minute rollover. When it reaches 0, `buzz` re-asserts with a fresh ring count.
  - A snooze press while `buzz`=0 is ignored.
- **alarm_en low:** `alarm_en`=0 clears `buzz` and the snooze counter on the next clk edge.
- **12 h display conversion:**
  - hour 0 → 12, pm=0.
  - hour 1..11 → same, pm=0.
  - hour 12 → 12, pm=1.
  - hour 13..23 → hour-12, pm=1.
- **BCD split:** tens/units by constant compare; no divider.

## Timing
- **Reset values:**
  - Time 00:00:00; alarm ALARM_RST_HR:ALARM_RST_MIN.
  - `buzz`=0, `state_o`=00, tic/ring/snooze counters 0.
  - Digits show 00:00:00 with `mode`=1, or 12:00:00 with `pm`=0 with `mode`=0.
- **Button latency:** a button high at clk edge N takes effect in the registers at edge N+3. Outputs change after N+3.
- **Digit outputs:** combinational from the registers; they update in the same cycle as the register.
- **Alarm assertion:** `buzz` rises on the same edge that sec goes 59→0 for the matching minute.
- **Ring duration:** `buzz` high for exactly ALARM_LEN_S ticks (ALARM_LEN_S·TIC_MAX cycles ± phase of the first tick).
- **Reset mid-operation:** a reset in any state returns to the reset values immediately, asynchronously.

## Test plan
1. Reset with `mode`=0, then `mode`=1 → digits 12:00:00 `pm`=0, then 00:00:00; `buzz`=0, `state_o`=00.
2. TIC_MAX=4; preload 23:59:59 via SET_TIME, return to RUN, wait 4 cycles → 00:00:00, with 24 h wrap.
3. Enter SET_TIME, 13 `hora` presses and 61 `min` presses → hour 13, minute 01, no hour carry. With `mode`=0 → digits 01:01, `pm`=1.
4. TIC_MAX=4, ALARM_LEN_S=3, alarm 00:02, `alarm_en`=1, start 00:01:00 → `buzz` rises at the edge showing 00:02:00 and falls after exactly 12 cycles.
5. During `buzz`, press `snooze` → `buzz` falls 3 cycles later; with SNOOZE_MIN=5 it re-asserts at 00:07:00.
6. During `buzz`, drop `alarm_en` → `buzz`=0 next edge. Assert `rst` while in SET_ALARM → `state_o`=00 and alarm back to 07:00.
